// File: rtl/instr_register_pkg.sv
// instr_register_pkg: shared register-file types plus arbiter id, state and latency types
package instr_register_pkg;
  typedef enum logic [3:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;
  typedef logic signed [31:0] operand_t;
  typedef logic [4:0] address_t;
  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;
  typedef logic [1:0] req_id_t;
  typedef enum logic [1:0] {IDLE, WR, RD_WAIT, RESP} arb_state_t;
  localparam int RD_LATENCY_MAX = 3;
  typedef logic [$clog2(RD_LATENCY_MAX+1)-1:0] lat_cnt_t;
endpackage

// File: rtl/instr_register_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; req/rr_ptr in, one-hot grant and winner id out
module rr_arbiter
  import instr_register_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  req_id_t            rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output req_id_t            winner
);
  logic found;
  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++)
      for (int i = 0; i < NUM_REQ; i++)
        if (!found && req[i] && i == (int'(rr_ptr) + k) % NUM_REQ) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          winner   = req_id_t'(i);
        end
  end
endmodule

// File: rtl/instr_register_arbiter.sv
// instr_register_arbiter: serializes NUM_REQ requesters onto instr_register
//   req_*  : per-requester valid/ready command ports (write or read)
//   rsp_*  : registered read response pulse with owner id, word and unwritten-error flag
//   load_en/write_pointer/read_pointer/opcode/operand_* : registered register-file drive
//   instruction_word : register-file read data; written_map : per-location written bitmap
module instr_register_arbiter
  import instr_register_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  logic [NUM_REQ-1:0] req_write,
  input  address_t           req_addr   [NUM_REQ],
  input  opcode_t            req_opcode [NUM_REQ],
  input  operand_t           req_op_a   [NUM_REQ],
  input  operand_t           req_op_b   [NUM_REQ],
  output logic               rsp_valid,
  output req_id_t            rsp_id,
  output instruction_t       rsp_word,
  output logic               rsp_err,
  output logic               load_en,
  output address_t           write_pointer,
  output address_t           read_pointer,
  output opcode_t            opcode,
  output operand_t           operand_a,
  output operand_t           operand_b,
  input  instruction_t       instruction_word,
  output logic [31:0]        written_map
);
  arb_state_t   state_q, state_d;
  req_id_t      rr_ptr_q, rr_ptr_d, id_q, id_d, winner;
  lat_cnt_t     lat_cnt_q, lat_cnt_d;
  logic         err_q, err_d;
  logic         load_en_q, load_en_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  req_id_t      rsp_id_q, rsp_id_d;
  instruction_t rsp_word_q, rsp_word_d;
  address_t     write_pointer_q, write_pointer_d, read_pointer_q, read_pointer_d;
  opcode_t      opcode_q, opcode_d;
  operand_t     operand_a_q, operand_a_d, operand_b_q, operand_b_d;
  logic [31:0]  written_map_q, written_map_d;
  logic [NUM_REQ-1:0] grant;
  logic         accept, sel_write, sel_known;
  address_t     sel_addr;
  opcode_t      sel_opc;
  operand_t     sel_a, sel_b;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req    (req_valid),
    .rr_ptr (rr_ptr_q),
    .grant  (grant),
    .winner (winner)
  );

  assign accept    = (state_q == IDLE) && |req_valid;
  assign req_ready = (state_q == IDLE) ? grant : '0;
  assign sel_known = written_map_q[sel_addr];

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_opc   = ZERO;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i];
        sel_opc   = req_opcode[i];
        sel_a     = req_op_a[i];
        sel_b     = req_op_b[i];
      end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      rr_ptr_q        <= '0;
      id_q            <= '0;
      lat_cnt_q       <= '0;
      err_q           <= 1'b0;
      load_en_q       <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_err_q       <= 1'b0;
      rsp_id_q        <= '0;
      rsp_word_q      <= '0;
      write_pointer_q <= '0;
      read_pointer_q  <= 5'h1F;
      opcode_q        <= ZERO;
      operand_a_q     <= '0;
      operand_b_q     <= '0;
      written_map_q   <= '0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      id_q            <= id_d;
      lat_cnt_q       <= lat_cnt_d;
      err_q           <= err_d;
      load_en_q       <= load_en_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_err_q       <= rsp_err_d;
      rsp_id_q        <= rsp_id_d;
      rsp_word_q      <= rsp_word_d;
      write_pointer_q <= write_pointer_d;
      read_pointer_q  <= read_pointer_d;
      opcode_q        <= opcode_d;
      operand_a_q     <= operand_a_d;
      operand_b_q     <= operand_b_d;
      written_map_q   <= written_map_d;
    end
  end

  // Reads of never-written locations skip RD_WAIT and answer with an error.
  always_comb begin
    state_d = (state_q == WR || state_q == RESP) ? IDLE :
              (state_q == RD_WAIT) ? (lat_cnt_q == '0 ? RESP : RD_WAIT) :
              !accept ? IDLE :
              sel_write ? WR :
              (sel_known && RD_LATENCY > 0) ? RD_WAIT : RESP;
  end

  always_comb begin
    rr_ptr_d        = accept ? (int'(winner) == NUM_REQ - 1 ? '0 : winner + req_id_t'(1)) : rr_ptr_q;
    id_d            = accept ? winner : id_q;
    err_d           = accept ? !sel_write && !sel_known : err_q;
    lat_cnt_d       = accept ? lat_cnt_t'(RD_LATENCY - 1) :
                      (state_q == RD_WAIT) ? lat_cnt_q - lat_cnt_t'(1) : lat_cnt_q;
    load_en_d       = accept && sel_write;
    write_pointer_d = load_en_d ? sel_addr : write_pointer_q;
    opcode_d        = load_en_d ? sel_opc : opcode_q;
    operand_a_d     = load_en_d ? sel_a : operand_a_q;
    operand_b_d     = load_en_d ? sel_b : operand_b_q;
    written_map_d   = written_map_q | (load_en_d ? 32'(1) << sel_addr : 32'd0);
    read_pointer_d  = (accept && !sel_write && sel_known) ? sel_addr : read_pointer_q;
    rsp_valid_d     = state_q == RESP;
    rsp_id_d        = rsp_valid_d ? id_q : rsp_id_q;
    rsp_err_d       = rsp_valid_d ? err_q : rsp_err_q;
    rsp_word_d      = rsp_valid_d ? (err_q ? '0 : instruction_word) : rsp_word_q;
  end

  assign load_en       = load_en_q;
  assign write_pointer = write_pointer_q;
  assign read_pointer  = read_pointer_q;
  assign opcode        = opcode_q;
  assign operand_a     = operand_a_q;
  assign operand_b     = operand_b_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = rsp_id_q;
  assign rsp_word      = rsp_word_q;
  assign rsp_err       = rsp_err_q;
  assign written_map   = written_map_q;
endmodule
